riscv_obi_initiator: RTL and testbench
======================================

# riscv_obi_initiator

Directed OBI initiator for the core testbench, driving the data port of an OBI responder such as the rvalid stall model. It takes single-beat commands on a valid/ready interface and issues them as OBI address-phase transactions. It tracks granted-but-unanswered transactions in order and returns each response on a registered response port. The block sits between the bench sequencer and the memory model.

## Interface
- MAX_OUTSTANDING, default 4: maximum granted transactions awaiting rvalid; power of two, 1..8.
- OUT_WL, default $clog2(MAX_OUTSTANDING+1): width of the outstanding counter.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_be_i  in  4  byte enables.
- cmd_addr_i  in  32  byte address.
- cmd_wdata_i  in  32  write data.
- req_o  out  1  OBI request.
- gnt_i  in  1  OBI grant.
- addr_o  out  32  OBI address.
- we_o  out  1  OBI write enable.
- be_o  out  4  OBI byte enables.
- wdata_o  out  32  OBI write data.
- rvalid_i  in  1  OBI response valid.
- rdata_i  in  32  OBI read data.
- req_gap_i  in  4  idle cycles inserted after each grant (0..15).
- rsp_valid_o  out  1  response presented, one cycle pulse.
- rsp_we_o  out  1  type of the transaction being answered.
- rsp_rdata_o  out  32  read data; 0 for writes.
- outstanding_o  out  OUT_WL  granted transactions not yet answered.
- err_o  out  1  sticky: rvalid_i seen with outstanding_o == 0.

## Operation
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - cmd_ready_o = (outstanding_o < MAX_OUTSTANDING).
  - On accept, capture cmd_addr_i, cmd_we_i, cmd_be_i and cmd_wdata_i into the address-phase registers, then go to REQ.
- REQ:
  - req_o = 1. addr_o, we_o, be_o and wdata_o stay frozen until the cycle with gnt_i = 1.
  - On req_o && gnt_i, push we_o into the in-order tracking FIFO (depth MAX_OUTSTANDING) and increment the outstanding count.
  - Next state is IDLE if the effective gap is 0. Otherwise load the gap counter with req_gap_i and go to GAP.
- GAP: decrement the counter each cycle; at 1, go to IDLE. cmd_ready_o = 0.
- cmd_ready_o = 0 in REQ and GAP. At most one command is in flight in the address phase.
- Response path:
  - rvalid_i with count > 0 pops the FIFO head.
  - Next cycle: rsp_valid_o = 1, rsp_we_o = head, rsp_rdata_o = head ? 0 : rdata_i (registered).
- Push and pop in the same cycle leave the count unchanged; both pointers advance.
- Pointers are modulo MAX_OUTSTANDING with a wrap bit. Full/empty is judged on the wrap bit.
- rvalid_i with count == 0: no pop, no rsp_valid_o, err_o set to 1 until reset.
- Address-phase outputs hold their last values while req_o = 0; they carry no meaning then.

## Timing
- Reset values: all outputs 0. cmd_ready_o rises in the first cycle after reset release. FSM = IDLE; pointers, count and gap counter = 0; err_o = 0.
- Command accepted in cycle t: req_o = 1 from t+1.
- Grant in cycle g: req_o = 0 at g+1. With gap N, cmd_ready_o returns at g+1+N (gap 0: g+1). Next req_o rises at g+2+N at the earliest.
- Grant in cycle g: the earliest response accepted is at g+1. An rvalid_i in cycle g answers an earlier transaction.
- rvalid_i in cycle r: rsp_valid_o at r+1. outstanding_o is updated at r+1.
- An outstanding_o change permits cmd_ready_o in the same cycle it becomes visible.
- Reset asserted mid-transaction: all state clears immediately. Responses in flight are lost, and no rsp_valid_o is produced for them.

## Configuration
- RISCV_OBI_INIT_GAP_EN defined: req_gap_i is honoured and GAP is reachable.
- Not defined: req_gap_i is ignored, the effective gap is always 0, and the GAP state and gap counter are not built.

## Test plan
- Read: cmd read of 0x100 with be 0xF; gnt_i = 1 in the first REQ cycle; rvalid_i one cycle later with rdata 0xDEADBEEF -> req_o high for 1 cycle, rsp_valid_o = 1 with rsp_rdata_o = 0xDEADBEEF, outstanding_o goes 1 then 0.
- Grant stall: gnt_i held low for 5 cycles on a write of 0xA5A5A5A5 to 0x200 -> req_o high for 6 cycles, addr_o/we_o/be_o/wdata_o constant, cmd_ready_o = 0 throughout.
- Full: 4 reads granted with no rvalid -> outstanding_o = 4 and cmd_ready_o = 0. One rvalid_i -> outstanding_o = 3 and cmd_ready_o = 1 one cycle later.
- Ordering: write, then read, both granted; rvalid_i twice with rdata 0x11111111 then 0x22222222 -> first response rsp_we_o = 1 with rsp_rdata_o = 0; second rsp_we_o = 0 with rsp_rdata_o = 0x22222222. rvalid_i coincident with the read's gnt leaves outstanding_o = 1.
- Gap: req_gap_i = 3 -> the second req_o rises 3 cycles later than with req_gap_i = 0 when RISCV_OBI_INIT_GAP_EN is defined; no difference when it is undefined.
- Errors and reset: rvalid_i with outstanding_o = 0 -> no rsp_valid_o, err_o = 1 and held. rst_ni pulsed while in REQ with 2 outstanding -> all outputs 0, err_o = 0, and the next rvalid_i sets err_o.

Source files
------------

// File: rtl/riscv_obi_initiator.sv
// Purpose: turns single-beat commands into OBI address phases and returns in-order responses.
// Latency: cmd accepted in t -> req_o from t+1; rvalid_i in r -> rsp_valid_o at r+1.
// Backpressure: cmd_ready_o low during an address phase, a post-grant gap, or when MAX_OUTSTANDING are unanswered.
// Optional: define RISCV_OBI_INIT_GAP_EN to honour req_gap_i (GAP state and gap counter).
module riscv_obi_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUT_WL          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [3:0]        cmd_be_i,
  input  logic [31:0]       cmd_addr_i,
  input  logic [31:0]       cmd_wdata_i,
  output logic              req_o,
  input  logic              gnt_i,
  output logic [31:0]       addr_o,
  output logic              we_o,
  output logic [3:0]        be_o,
  output logic [31:0]       wdata_o,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  input  logic [3:0]        req_gap_i,
  output logic              rsp_valid_o,
  output logic              rsp_we_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [OUT_WL-1:0] outstanding_o,
  output logic              err_o
);

  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [AW-1:0]     LAST_IDX = AW'(MAX_OUTSTANDING - 1);
  localparam logic [OUT_WL-1:0] MAX_CNT  = OUT_WL'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ready_en_q;
  logic              cmd_rdy, cmd_acc, req;
  logic [31:0]       addr_q, wdata_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic              trk_we_q [MAX_OUTSTANDING];
  logic [AW-1:0]     wr_idx_q, rd_idx_q;
  logic              wr_wrap_q, rd_wrap_q;
  logic [OUT_WL-1:0] cnt_q;
  logic              fifo_empty, fifo_full, push, pop;
  logic              rsp_vld_q, rsp_we_q, err_q;
  logic [31:0]       rsp_rdata_q;

  assign cmd_ready_o   = cmd_rdy;
  assign req_o         = req;
  assign addr_o        = addr_q;
  assign we_o          = we_q;
  assign be_o          = be_q;
  assign wdata_o       = wdata_q;
  assign rsp_valid_o   = rsp_vld_q;
  assign rsp_we_o      = rsp_we_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Same index with equal wrap bits is empty; same index with differing wrap bits is full.
  assign fifo_empty = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
  assign fifo_full  = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
  assign cmd_acc    = cmd_valid_i && cmd_rdy;
  assign push       = req && gnt_i && !fifo_full;
  assign pop        = rvalid_i && !fifo_empty;

`ifdef RISCV_OBI_INIT_GAP_EN
  logic [3:0] gap_q;

  // Gap counter: loaded at grant, counts down while idling in GAP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_q <= 4'd0;
    end else if (state_q == REQ && gnt_i) begin
      gap_q <= req_gap_i;
    end else if (state_q == GAP) begin
      gap_q <= gap_q - 4'd1;
    end
  end
`else
  logic unused_gap;
  assign unused_gap = ^req_gap_i;
`endif

  // State register plus a flag that keeps cmd_ready_o low until the first edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state and handshake outputs; ready depends on the count visible this cycle.
  always_comb begin
    state_d = state_q;
    cmd_rdy = 1'b0;
    req     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_rdy = ready_en_q && (cnt_q < MAX_CNT);
        if (cmd_valid_i && cmd_rdy) state_d = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (gnt_i) begin
`ifdef RISCV_OBI_INIT_GAP_EN
          state_d = (req_gap_i == 4'd0) ? IDLE : GAP;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef RISCV_OBI_INIT_GAP_EN
      GAP: begin
        if (gap_q == 4'd1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Address-phase registers: captured on accept, frozen until the next accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else if (cmd_acc) begin
      addr_q  <= cmd_addr_i;
      we_q    <= cmd_we_i;
      be_q    <= cmd_be_i;
      wdata_q <= cmd_wdata_i;
    end
  end

  // Tracking storage: transaction type of each granted request, in grant order.
  always_ff @(posedge clk_i) begin
    if (push) trk_we_q[wr_idx_q] <= we_q;
  end

  // Pointers and outstanding count; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_wrap_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (push) begin
        if (wr_idx_q == LAST_IDX) begin
          wr_idx_q  <= '0;
          wr_wrap_q <= ~wr_wrap_q;
        end else begin
          wr_idx_q <= wr_idx_q + AW'(1);
        end
      end
      if (pop) begin
        if (rd_idx_q == LAST_IDX) begin
          rd_idx_q  <= '0;
          rd_wrap_q <= ~rd_wrap_q;
        end else begin
          rd_idx_q <= rd_idx_q + AW'(1);
        end
      end
      if (push && !pop) cnt_q <= cnt_q + OUT_WL'(1);
      else if (pop && !push) cnt_q <= cnt_q - OUT_WL'(1);
    end
  end

  // Registered response port and sticky error on an unsolicited rvalid_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      rsp_vld_q <= pop;
      if (pop) begin
        rsp_we_q    <= trk_we_q[rd_idx_q];
        rsp_rdata_q <= trk_we_q[rd_idx_q] ? 32'd0 : rdata_i;
      end
      if (rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_obi_initiator.sv
// Directed bench for riscv_obi_initiator: issues commands, grants, responses;
// expected responses are queued when rvalid_i is driven and compared when rsp_valid_o fires.
// Works with or without RISCV_OBI_INIT_GAP_EN defined.
module tb_riscv_obi_initiator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [3:0]  cmd_be_i = 4'd0;
  logic [31:0] cmd_addr_i = 32'd0;
  logic [31:0] cmd_wdata_i = 32'd0;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = 32'd0;
  logic [3:0]  req_gap_i = 4'd0;
  logic        rsp_valid_o;
  logic        rsp_we_o;
  logic [31:0] rsp_rdata_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;
  logic        txn_q [$];
  logic [32:0] exp_q [$];

  riscv_obi_initiator dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_be_i(cmd_be_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .req_gap_i(req_gap_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_rdata_o(rsp_rdata_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every rsp_valid_o.
  always @(negedge clk_i) begin : mon
    logic [32:0] e;
    if (rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rsp_we", 32'(rsp_we_o), 32'(e[32]));
        chk("sb_rsp_rdata", rsp_rdata_o, e[31:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Offer a command, wait (bounded) for ready, finish in the first REQ cycle.
  task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_be_i    = be;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    while (!cmd_ready_o && n < 40) begin
      cyc();
      n++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
    cyc();
    cmd_valid_i = 1'b0;
    chk("req_rise", 32'(req_o), 32'd1);
  endtask

  task automatic grant(input logic we);
    gnt_i = 1'b1;
    txn_q.push_back(we);
    cyc();
    gnt_i = 1'b0;
    chk("req_fall", 32'(req_o), 32'd0);
  endtask

  task automatic respond(input logic [31:0] data);
    logic w;
    rvalid_i = 1'b1;
    rdata_i  = data;
    if (txn_q.size() == 0) begin
      chk("tb_txn_underflow", 32'(txn_q.size()), 32'd1);
    end else begin
      w = txn_q.pop_front();
      exp_q.push_back({w, w ? 32'd0 : data});
    end
    cyc();
    rvalid_i = 1'b0;
    rdata_i  = 32'd0;
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
  endtask

  // Count cycles from the grant's next cycle until the following req_o rises.
  task automatic gap_run(input logic [3:0] gap, output int n);
    req_gap_i = gap;
    send(1'b0, 4'hF, 32'h500, 32'd0);
    grant(1'b0);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = 32'h504;
    n = 0;
    while (!req_o && n < 40) begin
      cyc();
      n++;
    end
    cmd_valid_i = 1'b0;
    chk("gap_req_seen", 32'(req_o), 32'd1);
    grant(1'b0);
    req_gap_i = 4'd0;
    respond(32'h55);
    respond(32'h66);
  endtask

  initial begin
    int n0, n3;
    logic w;

    // Reset state
    cyc();
    cyc();
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    rst_ni = 1'b1;
    #1;
    chk("rel_cmd_ready_0", 32'(cmd_ready_o), 32'd0);
    cyc();
    chk("rel_cmd_ready_1", 32'(cmd_ready_o), 32'd1);

    // Single read
    send(1'b0, 4'hF, 32'h100, 32'd0);
    chk("rd_addr", addr_o, 32'h100);
    chk("rd_we", 32'(we_o), 32'd0);
    chk("rd_be", 32'(be_o), 32'hF);
    grant(1'b0);
    chk("rd_out_1", 32'(outstanding_o), 32'd1);
    chk("rd_ready_after_gnt", 32'(cmd_ready_o), 32'd1);
    respond(32'hDEADBEEF);
    chk("rd_out_0", 32'(outstanding_o), 32'd0);
    chk("rd_rdata", rsp_rdata_o, 32'hDEADBEEF);
    cyc();
    chk("rd_rsp_pulse", 32'(rsp_valid_o), 32'd0);

    // Grant stall on a write: address phase frozen for 6 cycles
    send(1'b1, 4'h3, 32'h200, 32'hA5A5A5A5);
    cmd_addr_i  = 32'hFFFFFFFF;
    cmd_wdata_i = 32'h0;
    cmd_be_i    = 4'h0;
    cmd_we_i    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_req", 32'(req_o), 32'd1);
      chk("st_addr", addr_o, 32'h200);
      chk("st_we", 32'(we_o), 32'd1);
      chk("st_be", 32'(be_o), 32'h3);
      chk("st_wdata", wdata_o, 32'hA5A5A5A5);
      chk("st_ready", 32'(cmd_ready_o), 32'd0);
      cyc();
    end
    chk("st_req_6", 32'(req_o), 32'd1);
    grant(1'b1);
    chk("st_out_1", 32'(outstanding_o), 32'd1);
    respond(32'h12345678);
    chk("st_rsp_rdata_zero", rsp_rdata_o, 32'd0);

    // Full: four reads granted, no responses
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 4'hF, 32'h300 + 32'(4 * i), 32'd0);
      grant(1'b0);
    end
    chk("full_out_4", 32'(outstanding_o), 32'd4);
    chk("full_ready_0", 32'(cmd_ready_o), 32'd0);
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_no_req", 32'(req_o), 32'd0);
      chk("full_ready_held", 32'(cmd_ready_o), 32'd0);
    end
    cmd_valid_i = 1'b0;
    respond(32'hA0);
    chk("full_out_3", 32'(outstanding_o), 32'd3);
    chk("full_ready_back", 32'(cmd_ready_o), 32'd1);
    respond(32'hA1);
    respond(32'hA2);
    respond(32'hA3);
    chk("full_out_drain", 32'(outstanding_o), 32'd0);

    // Ordering: write then read, rvalid coincident with the read's grant
    send(1'b1, 4'hF, 32'h400, 32'h5);
    grant(1'b1);
    send(1'b0, 4'hF, 32'h404, 32'd0);
    gnt_i    = 1'b1;
    rvalid_i = 1'b1;
    rdata_i  = 32'h11111111;
    w = txn_q.pop_front();
    exp_q.push_back({w, w ? 32'd0 : 32'h11111111});
    txn_q.push_back(1'b0);
    cyc();
    gnt_i    = 1'b0;
    rvalid_i = 1'b0;
    chk("ord_out_1", 32'(outstanding_o), 32'd1);
    chk("ord_rsp1_valid", 32'(rsp_valid_o), 32'd1);
    chk("ord_rsp1_we", 32'(rsp_we_o), 32'd1);
    chk("ord_rsp1_rdata", rsp_rdata_o, 32'd0);
    respond(32'h22222222);
    chk("ord_rsp2_we", 32'(rsp_we_o), 32'd0);
    chk("ord_rsp2_rdata", rsp_rdata_o, 32'h22222222);
    chk("ord_out_0", 32'(outstanding_o), 32'd0);

    // Gap after grant
    gap_run(4'd0, n0);
    gap_run(4'd3, n3);
    chk("gap0_delay", 32'(n0), 32'd1);
`ifdef RISCV_OBI_INIT_GAP_EN
    chk("gap3_delay", 32'(n3), 32'd4);
`else
    chk("gap3_delay", 32'(n3), 32'd1);
`endif

    // Unsolicited rvalid sets sticky error
    chk("err_pre_out", 32'(outstanding_o), 32'd0);
    rvalid_i = 1'b1;
    rdata_i  = 32'h99;
    cyc();
    rvalid_i = 1'b0;
    chk("err_set", 32'(err_o), 32'd1);
    chk("err_no_rsp", 32'(rsp_valid_o), 32'd0);
    cyc();
    cyc();
    chk("err_held", 32'(err_o), 32'd1);

    // Reset while in REQ with two outstanding
    send(1'b0, 4'hF, 32'h600, 32'd0);
    grant(1'b0);
    send(1'b0, 4'hF, 32'h604, 32'd0);
    grant(1'b0);
    send(1'b0, 4'hF, 32'h608, 32'd0);
    chk("mr_out_2", 32'(outstanding_o), 32'd2);
    rst_ni = 1'b0;
    #1;
    txn_q.delete();
    exp_q.delete();
    chk("mr_req", 32'(req_o), 32'd0);
    chk("mr_out", 32'(outstanding_o), 32'd0);
    chk("mr_err", 32'(err_o), 32'd0);
    chk("mr_ready", 32'(cmd_ready_o), 32'd0);
    chk("mr_addr", addr_o, 32'd0);
    chk("mr_be", 32'(be_o), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid_o), 32'd0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();
    chk("mr_ready_back", 32'(cmd_ready_o), 32'd1);
    rvalid_i = 1'b1;
    rdata_i  = 32'h77;
    cyc();
    rvalid_i = 1'b0;
    chk("mr_err_again", 32'(err_o), 32'd1);
    chk("mr_no_rsp", 32'(rsp_valid_o), 32'd0);
    cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
